four_two_encoder_seq: RTL

FOUR_TWO_ENCODER_SEQ -- requirements
Module: four_two_encoder_seq

---
 rtl/enc_pkg.sv | 19 +
 rtl/prio_enc4.sv | 28 ++
 rtl/four_two_encoder_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/enc_pkg.sv
// Shared types and widths for the sequential 4-to-2 priority encoder.
package enc_pkg;

  localparam int D_W       = 4;
  localparam int A_W       = 2;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic           multi_hot;
  } entry_t;

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder: highest set bit wins, plus
// multi-hot and all-zero flags for the request word.
module prio_enc4
  import enc_pkg::*;
(
  input  logic [D_W-1:0] d,
  output logic [A_W-1:0] a,
  output logic           multi_hot,
  output logic           zero
);

  logic [2:0] ones;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    a = 2'd0;
    if (d[3])      a = 2'd3;
    else if (d[2]) a = 2'd2;
    else if (d[1]) a = 2'd1;
    else           a = 2'd0;
  end

  assign ones      = 3'(d[0]) + 3'(d[1]) + 3'(d[2]) + 3'(d[3]);
  assign multi_hot = (ones >= 3'd2);
  assign zero      = (d == '0);

endmodule

// File: rtl/four_two_encoder_seq.sv
// Sequential 4-to-2 priority encoder with a 2-entry valid/ready output FIFO.
// Optional macro ENC_ERR_CNT_EN adds a saturating count of non-one-hot words.
module four_two_encoder_seq
  import enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [D_W-1:0]       d,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W-1:0]       a,
  output logic                 multi_hot
`ifdef ENC_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  fifo_state_e    state_q, state_d;
  entry_t         head_q, head_d;
  entry_t         tail_q, tail_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  entry_t         new_entry;
  logic           new_zero;
  logic           accept, pop, push;

  prio_enc4 u_prio_enc4 (
    .d         (d),
    .a         (new_entry.a),
    .multi_hot (new_entry.multi_hot),
    .zero      (new_zero)
  );

  assign accept = in_valid && in_ready_q;
  assign pop    = out_valid_q && out_ready;
  // An all-zero word is consumed by the handshake but never stored.
  assign push   = accept && !new_zero;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = new_entry;
            state_d = TWO;
          end
          2'b01: state_d = EMPTY;
          2'b11: head_d  = new_entry;
          default: ;
        endcase
      end
      TWO: begin
        // in_ready is low here, so only a pop can move the FIFO.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // NOTE: the two entries are reset as well as the state, because a and
  // multi_hot are driven straight from the head entry and must read zero
  // after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a         = head_q.a;
  assign multi_hot = head_q.multi_hot;

`ifdef ENC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && (new_zero || new_entry.multi_hot) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
